// File: rtl/exc_ctrl_pkg.sv
// Shared types and constants for the exception commit controller: FSM states,
// exception-flag bit positions, Cause.ExcCode values and vector offsets.
package exc_ctrl_pkg;

   typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_COMMIT, S_REDIRECT} state_e;
   typedef enum logic [1:0] {CLS_EXC, CLS_ERET, CLS_REFETCH} exc_class_e;

   localparam int NFLAGS = 14;

   // Flag bit positions; lower index = higher priority
   localparam int F_INT    = 0;
   localparam int F_IADEL  = 1;
   localparam int F_TLBR   = 2;
   localparam int F_TLBI   = 3;
   localparam int F_RI     = 4;
   localparam int F_SYS    = 5;
   localparam int F_BP     = 6;
   localparam int F_OV     = 7;
   localparam int F_TR     = 8;
   localparam int F_DADEL  = 9;
   localparam int F_DADES  = 10;
   localparam int F_TLBMOD = 11;
   localparam int F_ERET   = 12;
   localparam int F_REFET  = 13;

   localparam logic [4:0] EC_INT  = 5'h00;
   localparam logic [4:0] EC_MOD  = 5'h01;
   localparam logic [4:0] EC_TLBL = 5'h02;
   localparam logic [4:0] EC_TLBS = 5'h03;
   localparam logic [4:0] EC_ADEL = 5'h04;
   localparam logic [4:0] EC_ADES = 5'h05;
   localparam logic [4:0] EC_SYS  = 5'h08;
   localparam logic [4:0] EC_BP   = 5'h09;
   localparam logic [4:0] EC_RI   = 5'h0a;
   localparam logic [4:0] EC_OV   = 5'h0c;
   localparam logic [4:0] EC_TR   = 5'h0d;

   localparam int ST_BEV = 22;
   localparam int ST_EXL = 1;

   localparam logic [31:0] VEC_OFF_REFILL  = 32'h0000_0000;
   localparam logic [31:0] VEC_OFF_GENERAL = 32'h0000_0180;

endpackage

// File: rtl/exc_prio_enc.sv
// Priority encoder: captured exception flags -> ExcCode, commit class and
// BadVAddr/refill qualifiers. Purely combinational.
module exc_prio_enc
   import exc_ctrl_pkg::*;
(
   input  logic [NFLAGS-1:0] i_flags,
   input  logic              i_is_store,
   output logic [4:0]        o_exccode,
   output exc_class_e        o_cls,
   output logic              o_needs_bva,
   output logic              o_is_refill,
   output logic              o_bva_from_pc
);

   always_comb begin
      o_exccode     = EC_INT;
      o_cls         = CLS_EXC;
      o_needs_bva   = 1'b0;
      o_is_refill   = 1'b0;
      o_bva_from_pc = 1'b0;
      if (i_flags[F_INT]) begin
         o_exccode = EC_INT;
      end else if (i_flags[F_IADEL]) begin
         o_exccode     = EC_ADEL;
         o_needs_bva   = 1'b1;
         o_bva_from_pc = 1'b1;
      end else if (i_flags[F_TLBR] || i_flags[F_TLBI]) begin
         o_exccode   = i_is_store ? EC_TLBS : EC_TLBL;
         o_needs_bva = 1'b1;
         o_is_refill = i_flags[F_TLBR];
      end else if (i_flags[F_RI]) begin
         o_exccode = EC_RI;
      end else if (i_flags[F_SYS]) begin
         o_exccode = EC_SYS;
      end else if (i_flags[F_BP]) begin
         o_exccode = EC_BP;
      end else if (i_flags[F_OV]) begin
         o_exccode = EC_OV;
      end else if (i_flags[F_TR]) begin
         o_exccode = EC_TR;
      end else if (i_flags[F_DADEL] || i_flags[F_DADES]) begin
         // either data address-error bit; the access direction picks the code
         o_exccode   = i_is_store ? EC_ADES : EC_ADEL;
         o_needs_bva = 1'b1;
      end else if (i_flags[F_TLBMOD]) begin
         o_exccode   = EC_MOD;
         o_needs_bva = 1'b1;
      end else if (i_flags[F_ERET]) begin
         o_cls = CLS_ERET;
      end else begin
         o_cls = CLS_REFETCH;
      end
   end

endmodule

// File: rtl/exception_commit_ctrl.sv
// Precise exception / ERET / refetch commit sequencer between MEM, CP0 and IF.
//  state    | meaning
//  IDLE     | waiting for exc_valid, no flush
//  DRAIN    | waiting for data-bus traffic to finish (bounded by DRAIN_MAX)
//  COMMIT   | single cycle: CP0 strobes driven, redirect target computed
//  REDIRECT | redirect_valid held until IF acks
module exception_commit_ctrl
   import exc_ctrl_pkg::*;
#(
   parameter int          DRAIN_MAX  = 64,
   parameter logic [31:0] RESET_BASE = 32'hBFC0_0200,
   parameter logic [31:0] NORM_BASE  = 32'h8000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              exc_valid,
   input  logic [NFLAGS-1:0] exc_flags,
   input  logic [31:0]       exc_pc,
   input  logic              exc_in_ds,
   input  logic [31:0]       exc_badvaddr,
   input  logic              exc_is_store,
   input  logic [31:0]       cp0_status,
   input  logic [31:0]       cp0_epc,
   input  logic              mem_busy,
   input  logic              redirect_ack,
   output logic              flush_req,
   output logic              cp0_wr_en,
   output logic [4:0]        cp0_exccode,
   output logic              cp0_epc_wr,
   output logic [31:0]       cp0_epc_val,
   output logic              cp0_bd,
   output logic              cp0_bva_wr,
   output logic [31:0]       cp0_bva_val,
   output logic              cp0_exl_set,
   output logic              cp0_exl_clr,
   output logic              redirect_valid,
   output logic [31:0]       redirect_pc,
   output logic              drain_timeout
);

   // The IDLE cycle counts toward the drain budget, hence the load of DRAIN_MAX-2
   localparam int               CNT_W    = (DRAIN_MAX > 2) ? $clog2(DRAIN_MAX - 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_MAX - 2);

   state_e            r_state;
   logic [NFLAGS-1:0] r_flags;
   logic [31:0]       r_pc;
   logic              r_ds;
   logic [31:0]       r_bva;
   logic              r_store;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_flush;
   logic              r_rvalid;
   logic [31:0]       r_rpc;
   logic              r_timeout;

   logic [4:0]  w_exccode;
   exc_class_e  w_cls;
   logic        w_needs_bva;
   logic        w_is_refill;
   logic        w_bva_from_pc;
   logic        w_exl;
   logic        w_bev;
   logic        w_commit;
   logic        w_exc;
   logic        w_cnt_tc;
   logic [31:0] w_vec;
   logic [31:0] w_target;
   logic        w_unused_status;

   exc_prio_enc u_prio (
      .i_flags       (r_flags),
      .i_is_store    (r_store),
      .o_exccode     (w_exccode),
      .o_cls         (w_cls),
      .o_needs_bva   (w_needs_bva),
      .o_is_refill   (w_is_refill),
      .o_bva_from_pc (w_bva_from_pc)
   );

   assign w_exl           = cp0_status[ST_EXL];
   assign w_bev           = cp0_status[ST_BEV];
   assign w_unused_status = ^{cp0_status[31:23], cp0_status[21:2], cp0_status[0]};
   assign w_commit        = (r_state == S_COMMIT);
   assign w_exc           = w_commit && (w_cls == CLS_EXC);
   assign w_cnt_tc        = (r_cnt == '0);

   // CP0 strobes are live only in COMMIT so they see Status as it stands then
   assign cp0_wr_en   = w_exc;
   assign cp0_exl_set = w_exc;
   assign cp0_exl_clr = w_commit && (w_cls == CLS_ERET);
   assign cp0_exccode = w_exc ? w_exccode : 5'd0;
   assign cp0_epc_wr  = w_exc && !w_exl;
   assign cp0_epc_val = cp0_epc_wr ? (r_ds ? r_pc - 32'd4 : r_pc) : 32'd0;
   assign cp0_bd      = cp0_epc_wr && r_ds;
   assign cp0_bva_wr  = w_exc && w_needs_bva;
   assign cp0_bva_val = cp0_bva_wr ? (w_bva_from_pc ? r_pc : r_bva) : 32'd0;

   assign w_vec = (w_bev ? RESET_BASE : NORM_BASE)
                + ((w_is_refill && !w_exl) ? VEC_OFF_REFILL : VEC_OFF_GENERAL);

   always_comb begin
      w_target = r_pc;
      case (w_cls)
         CLS_EXC:  w_target = w_vec;
         CLS_ERET: w_target = cp0_epc;
         default:  w_target = r_pc;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_flags   <= '0;
         r_pc      <= '0;
         r_ds      <= 1'b0;
         r_bva     <= '0;
         r_store   <= 1'b0;
         r_cnt     <= '0;
         r_flush   <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rpc     <= '0;
         r_timeout <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (exc_valid) begin
                  r_flags <= exc_flags;
                  r_pc    <= exc_pc;
                  r_ds    <= exc_in_ds;
                  r_bva   <= exc_badvaddr;
                  r_store <= exc_is_store;
                  r_cnt   <= CNT_LOAD;
                  r_flush <= 1'b1;
                  r_state <= mem_busy ? S_DRAIN : S_COMMIT;
               end
            end
            S_DRAIN: begin
               if (w_cnt_tc) begin
                  r_timeout <= 1'b1;
                  r_state   <= S_COMMIT;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
                  if (!mem_busy) r_state <= S_COMMIT;
               end
            end
            S_COMMIT: begin
               r_rpc    <= w_target;
               r_rvalid <= 1'b1;
               r_state  <= S_REDIRECT;
            end
            S_REDIRECT: begin
               if (redirect_ack) begin
                  r_rvalid <= 1'b0;
                  r_flush  <= 1'b0;
                  r_rpc    <= '0;
                  r_state  <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign flush_req      = r_flush;
   assign redirect_valid = r_rvalid;
   assign redirect_pc    = r_rpc;
   assign drain_timeout  = r_timeout;

endmodule

// File: tb/tb_exception_commit_ctrl.sv
// Self-checking bench for exception_commit_ctrl: directed cases plus random
// transactions checked against a table-driven priority/vector model.
module tb_exception_commit_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        exc_valid;
   logic [13:0] exc_flags;
   logic [31:0] exc_pc;
   logic        exc_in_ds;
   logic [31:0] exc_badvaddr;
   logic        exc_is_store;
   logic [31:0] cp0_status;
   logic [31:0] cp0_epc;
   logic        mem_busy;
   logic        redirect_ack;
   logic        flush_req;
   logic        cp0_wr_en;
   logic [4:0]  cp0_exccode;
   logic        cp0_epc_wr;
   logic [31:0] cp0_epc_val;
   logic        cp0_bd;
   logic        cp0_bva_wr;
   logic [31:0] cp0_bva_val;
   logic        cp0_exl_set;
   logic        cp0_exl_clr;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        drain_timeout;

   int n_checks = 0;
   int n_fail   = 0;
   logic exp_to = 1'b0;

   exception_commit_ctrl dut (
      .clk(clk), .rst(rst), .exc_valid(exc_valid), .exc_flags(exc_flags),
      .exc_pc(exc_pc), .exc_in_ds(exc_in_ds), .exc_badvaddr(exc_badvaddr),
      .exc_is_store(exc_is_store), .cp0_status(cp0_status), .cp0_epc(cp0_epc),
      .mem_busy(mem_busy), .redirect_ack(redirect_ack), .flush_req(flush_req),
      .cp0_wr_en(cp0_wr_en), .cp0_exccode(cp0_exccode), .cp0_epc_wr(cp0_epc_wr),
      .cp0_epc_val(cp0_epc_val), .cp0_bd(cp0_bd), .cp0_bva_wr(cp0_bva_wr),
      .cp0_bva_val(cp0_bva_val), .cp0_exl_set(cp0_exl_set), .cp0_exl_clr(cp0_exl_clr),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .drain_timeout(drain_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model. cls: 0 exception, 1 ERET, 2 refetch.
   task automatic model(input logic [13:0] fl, input logic st, input logic [31:0] pc,
                        input logic ds, input logic [31:0] bva, input logic [31:0] status,
                        input logic [31:0] epc,
                        output logic [10:0] strobes, output logic [31:0] epc_v,
                        output logic [31:0] bva_v, output logic [31:0] target);
      logic [4:0] codes [12];
      logic       bva_on [12];
      logic       exl, bev, ewr, bwr;
      int         hit;
      codes  = '{5'h00, 5'h04, st ? 5'h03 : 5'h02, st ? 5'h03 : 5'h02, 5'h0a, 5'h08,
                 5'h09, 5'h0c, 5'h0d, st ? 5'h05 : 5'h04, st ? 5'h05 : 5'h04, 5'h01};
      bva_on = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1};
      exl = status[1];
      bev = status[22];
      hit = -1;
      for (int i = 11; i >= 0; i--) if (fl[i]) hit = i;
      strobes = '0; epc_v = '0; bva_v = '0;
      if (hit >= 0) begin
         ewr = !exl;
         bwr = bva_on[hit];
         // {wr_en, exl_set, exl_clr, epc_wr, bd, bva_wr, exccode}
         strobes = {1'b1, 1'b1, 1'b0, ewr, ewr & ds, bwr, codes[hit]};
         if (ewr) epc_v = ds ? pc - 32'd4 : pc;
         if (bwr) bva_v = (hit == 1) ? pc : bva;
         target = (bev ? 32'hBFC0_0200 : 32'h8000_0000)
                + ((hit == 2 && !exl) ? 32'h0 : 32'h180);
      end else if (fl[12]) begin
         strobes = {2'b00, 1'b1, 8'h00};
         target  = epc;
      end else begin
         target = pc;
      end
   endtask

   task automatic noise();
      exc_valid    = 1'($urandom);
      exc_flags    = 14'($urandom);
      exc_pc       = $urandom;
      exc_badvaddr = $urandom;
      exc_in_ds    = 1'($urandom);
      exc_is_store = 1'($urandom);
   endtask

   task automatic txn(input string tag, input logic [13:0] fl, input logic [31:0] pc,
                      input logic ds, input logic [31:0] bva, input logic st,
                      input logic [31:0] status, input logic [31:0] epc,
                      input int busy_n, input int ack_dly);
      logic [10:0] e_str;
      logic [31:0] e_epc, e_bva, e_tgt;
      int          t_commit;
      model(fl, st, pc, ds, bva, status, epc, e_str, e_epc, e_bva, e_tgt);
      t_commit = (busy_n == 0) ? 1 : ((busy_n < 63 ? busy_n : 63) + 1);
      exc_valid = 1'b1; exc_flags = fl; exc_pc = pc; exc_in_ds = ds;
      exc_badvaddr = bva; exc_is_store = st; cp0_status = status; cp0_epc = epc;
      mem_busy = (busy_n > 0); redirect_ack = 1'b0;
      #1 chk({tag, ".idle"}, {31'd0, flush_req}, 32'd0);
      @(posedge clk); #1;
      for (int k = 1; k < t_commit; k++) begin
         noise();
         mem_busy = (k < busy_n);
         redirect_ack = 1'($urandom);
         #1 chk({tag, ".wait"}, {28'd0, flush_req, cp0_wr_en, cp0_exl_clr, redirect_valid},
                32'h8);
         @(posedge clk); #1;
      end
      noise();
      mem_busy = (t_commit < busy_n);
      redirect_ack = 1'($urandom);
      if (busy_n >= 63) exp_to = 1'b1;
      #1;
      chk({tag, ".strobes"}, {21'd0, cp0_wr_en, cp0_exl_set, cp0_exl_clr, cp0_epc_wr,
                              cp0_bd, cp0_bva_wr, cp0_exccode}, {21'd0, e_str});
      chk({tag, ".epc"}, cp0_epc_val, e_epc);
      chk({tag, ".bva"}, cp0_bva_val, e_bva);
      chk({tag, ".commit_flags"}, {30'd0, flush_req, redirect_valid}, 32'h2);
      chk({tag, ".timeout"}, {31'd0, drain_timeout}, {31'd0, exp_to});
      @(posedge clk); #1;
      redirect_ack = 1'b0;
      for (int d = 0; d < ack_dly; d++) begin
         noise();
         mem_busy = 1'($urandom);
         #1 chk({tag, ".hold"}, {redirect_valid, flush_req, 30'd0}, 32'hC000_0000);
         chk({tag, ".rpc_hold"}, redirect_pc, e_tgt);
         @(posedge clk); #1;
      end
      redirect_ack = 1'b1;
      #1 chk({tag, ".rvalid"}, {31'd0, redirect_valid}, 32'd1);
      chk({tag, ".rpc"}, redirect_pc, e_tgt);
      @(posedge clk); #1;
      redirect_ack = 1'b0; exc_valid = 1'b0; mem_busy = 1'b0;
      #1 chk({tag, ".done"}, {30'd0, flush_req, redirect_valid}, 32'd0);
   endtask

   initial begin
      logic [13:0] fl;
      int          mode, bn;
      rst = 1'b1; exc_valid = 1'b0; exc_flags = '0; exc_pc = '0; exc_in_ds = 1'b0;
      exc_badvaddr = '0; exc_is_store = 1'b0; cp0_status = '0; cp0_epc = '0;
      mem_busy = 1'b0; redirect_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset.outs", {19'd0, flush_req, cp0_wr_en, cp0_epc_wr, cp0_bd, cp0_bva_wr,
                         cp0_exl_set, cp0_exl_clr, redirect_valid, drain_timeout, cp0_exccode != 0,
                         cp0_epc_val != 0, cp0_bva_val != 0, redirect_pc != 0}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed cases
      txn("sys", 14'h1 << 5, 32'h8000_1000, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 0, 2);
      txn("ov_ds", 14'h1 << 7, 32'h8000_2004, 1'b1, 32'h1234_5678, 1'b0, 32'h0, 32'h0, 0, 0);
      txn("tlbr_st", 14'h1 << 2, 32'h8000_3000, 1'b0, 32'h0040_0010, 1'b1, 32'h0040_0000,
          32'h0, 0, 1);
      txn("tlbr_exl", 14'h1 << 2, 32'h8000_3000, 1'b0, 32'h0040_0010, 1'b1, 32'h0040_0002,
          32'h0, 0, 1);
      txn("busy10", 14'h1 << 6, 32'h8000_4000, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 10, 0);
      txn("eret", 14'h1 << 12, 32'h8000_5000, 1'b0, 32'h0, 1'b0, 32'h2, 32'h8000_0ABC, 0, 1);
      txn("int_ri", 14'h11, 32'h8000_6000, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 0, 0);
      txn("iadel", 14'h1 << 1, 32'h8000_7001, 1'b0, 32'hDEAD_0000, 1'b0, 32'h0, 32'h0, 0, 0);
      txn("refetch", 14'h1 << 13, 32'h8000_8000, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 3, 0);
      txn("busy62", 14'h1 << 8, 32'h8000_9000, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 62, 0);
      txn("busy_forever", 14'h1 << 10, 32'h8000_A000, 1'b0, 32'h0000_0FF1, 1'b1, 32'h0,
          32'h0, 100, 0);
      txn("pc_wrap_ds", 14'h1 << 11, 32'h0000_0000, 1'b1, 32'h5555_0000, 1'b1, 32'h0,
          32'h0, 0, 0);

      // Reset while a redirect is pending
      exc_valid = 1'b1; exc_flags = 14'h1 << 5; exc_pc = 32'h8000_B000; exc_in_ds = 1'b0;
      cp0_status = 32'h0; mem_busy = 1'b0;
      @(posedge clk); #1;
      exc_valid = 1'b0;
      @(posedge clk); #1;
      chk("rst_redir.pre", {31'd0, redirect_valid}, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_to = 1'b0;
      #1 chk("rst_redir.post", {29'd0, redirect_valid, flush_req, drain_timeout}, 32'd0);
      exc_valid = 1'b1; exc_flags = 14'h1 << 13; exc_pc = 32'h1357_9BDF;
      @(posedge clk); #1;
      exc_valid = 1'b0;
      #1 chk("rst_redir.accept", {31'd0, flush_req}, 32'd1);
      @(posedge clk); #1;
      redirect_ack = 1'b1;
      #1 chk("rst_redir.rpc", redirect_pc, 32'h1357_9BDF);
      @(posedge clk); #1;
      redirect_ack = 1'b0;
      #1 chk("rst_redir.done", {31'd0, flush_req}, 32'd0);

      // Random transactions
      for (int n = 0; n < 30; n++) begin
         mode = int'($urandom_range(0, 3));
         case (mode)
            0:       fl = 14'h1 << $urandom_range(0, 13);
            1:       fl = 14'($urandom);
            2:       fl = 14'h0;
            default: fl = {2'($urandom), 12'h0};
         endcase
         bn = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 12));
         txn($sformatf("rnd%0d", n), fl, $urandom, 1'($urandom), $urandom, 1'($urandom),
             $urandom, $urandom, bn, int'($urandom_range(0, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
